// File: rtl/jk_bank_ctrl.sv
// Command sequencer for a bank of JK flip-flops: expands clear/set/load/toggle,
// up/down counting and left rotation into per-cycle J/K/ENABLE drive.
module jk_bank_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic [WIDTH-1:0] en_out,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_CLEAR  = 3'd1;
  localparam logic [2:0] OP_SET    = 3'd2;
  localparam logic [2:0] OP_LOAD   = 3'd3;
  localparam logic [2:0] OP_TOGGLE = 3'd4;
  localparam logic [2:0] OP_UP     = 3'd5;
  localparam logic [2:0] OP_DOWN   = 3'd6;
  localparam logic [2:0] OP_ROTL   = 3'd7;

  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state_reg, state_next;
  logic [2:0]       op_reg;
  logic [WIDTH-1:0] data_reg;
  logic [CNT_W-1:0] remaining_reg, remaining_next;

  logic             accept;
  logic             is_count_op;
  logic [WIDTH-1:0] mask_up, mask_dn, rot_l;

  assign accept      = cmd_valid && (state_reg == IDLE) && !rst;
  assign is_count_op = (cmd_op == OP_UP) || (cmd_op == OP_DOWN) || (cmd_op == OP_ROTL);

  // Bits that change on +1 / -1 are exactly the bits to toggle.
  assign mask_up = q_in ^ (q_in + ONE_W);
  assign mask_dn = q_in ^ (q_in - ONE_W);

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rot
      assign rot_l[gi] = q_in[(gi + WIDTH - 1) % WIDTH];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      remaining_reg <= '0;
      op_reg        <= OP_NOP;
      data_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      remaining_reg <= remaining_next;
      if (accept) begin
        op_reg   <= cmd_op;
        data_reg <= cmd_data;
      end
    end
  end

  always_comb begin
    state_next     = state_reg;
    remaining_next = remaining_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (cmd_op == OP_NOP || (is_count_op && cmd_count == '0)) begin
            state_next     = FIN;
            remaining_next = '0;
          end else if (is_count_op) begin
            state_next     = RUN;
            remaining_next = cmd_count;
          end else begin
            state_next     = RUN;
            remaining_next = ONE_C;
          end
        end
      end
      RUN: begin
        remaining_next = remaining_reg - ONE_C;
        if (remaining_reg <= ONE_C) begin
          state_next = FIN;
        end
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_reg == IDLE) && !rst;
    busy      = (state_reg != IDLE) && !rst;
    done      = (state_reg == FIN) && !rst;
    j_out     = '0;
    k_out     = '0;
    en_out    = '0;
    if (state_reg == RUN && !rst) begin
      case (op_reg)
        OP_CLEAR: begin
          en_out = '1;
          k_out  = '1;
        end
        OP_SET: begin
          en_out = '1;
          j_out  = '1;
        end
        OP_LOAD: begin
          en_out = '1;
          j_out  = data_reg;
          k_out  = ~data_reg;
        end
        OP_TOGGLE: begin
          en_out = data_reg;
          j_out  = data_reg;
          k_out  = data_reg;
        end
        OP_UP: begin
          en_out = mask_up;
          j_out  = mask_up;
          k_out  = mask_up;
        end
        OP_DOWN: begin
          en_out = mask_dn;
          j_out  = mask_dn;
          k_out  = mask_dn;
        end
        OP_ROTL: begin
          en_out = '1;
          j_out  = rot_l;
          k_out  = ~rot_l;
        end
        default: begin
          en_out = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Randomized scoreboard bench for jk_bank_ctrl driving a behavioural JK bank;
// expected Q trajectories come from plain arithmetic on the bank value.
module tb_jk_bank_ctrl;

  localparam int W  = 4;
  localparam int CW = 8;

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_CLEAR  = 3'd1;
  localparam logic [2:0] OP_SET    = 3'd2;
  localparam logic [2:0] OP_LOAD   = 3'd3;
  localparam logic [2:0] OP_TOGGLE = 3'd4;
  localparam logic [2:0] OP_UP     = 3'd5;
  localparam logic [2:0] OP_DOWN   = 3'd6;
  localparam logic [2:0] OP_ROTL   = 3'd7;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_op = 3'd0;
  logic [W-1:0]  cmd_data = '0;
  logic [CW-1:0] cmd_count = '0;
  logic [W-1:0]  bank_q = '0;
  logic [W-1:0]  j_out, k_out, en_out;
  logic          busy, done;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic [W-1:0] en;
    logic [W-1:0] j;
    logic [W-1:0] k;
    logic [W-1:0] q;
  } step_t;

  typedef struct {
    int           t;
    int           n;
    logic [W-1:0] q;
  } done_t;

  step_t step_q[$];
  done_t done_q[$];
  logic [W-1:0] mdl_q = '0;

  jk_bank_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_count (cmd_count),
    .q_in      (bank_q),
    .j_out     (j_out),
    .k_out     (k_out),
    .en_out    (en_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // JK flip-flop bank: Q+ = J&~Q | ~K&Q where enabled.
  always @(posedge clk)
    bank_q <= (bank_q & ~en_out) | (en_out & ((j_out & ~bank_q) | (~k_out & bank_q)));

  function automatic logic [W-1:0] next_q(input logic [2:0] op, input logic [W-1:0] d,
                                          input logic [W-1:0] q);
    case (op)
      OP_CLEAR:  return '0;
      OP_SET:    return '1;
      OP_LOAD:   return d;
      OP_TOGGLE: return q ^ d;
      OP_UP:     return W'((int'(q) + 1) % (1 << W));
      OP_DOWN:   return W'((int'(q) + (1 << W) - 1) % (1 << W));
      OP_ROTL:   return W'(((int'(q) << 1) | (int'(q) >> (W - 1))) % (1 << W));
      default:   return q;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at #1 after a rising edge; returns at #1 after the acceptance edge.
  task automatic send(input logic [2:0] op, input logic [W-1:0] d, input logic [CW-1:0] cnt);
    int waited;
    int n;
    logic [W-1:0] q;
    logic [W-1:0] nq;
    step_t s;
    done_t r;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    cmd_count = cnt;
    waited    = 0;
    while (cmd_ready !== 1'b1 && waited < 300) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (cmd_ready !== 1'b1) begin
      check("ready_timeout", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    if (op == OP_NOP) n = 0;
    else if (op >= OP_UP) n = int'(cnt);
    else n = 1;
    q = mdl_q;
    for (int i = 0; i < n; i++) begin
      nq = next_q(op, d, q);
      if (op == OP_TOGGLE || op == OP_UP || op == OP_DOWN) begin
        s.en = q ^ nq; s.j = q ^ nq; s.k = q ^ nq;
      end else begin
        s.en = '1; s.j = nq; s.k = ~nq;
      end
      s.q = nq;
      step_q.push_back(s);
      q = nq;
    end
    r.t = cyc; r.n = n; r.q = q;
    done_q.push_back(r);
    mdl_q = q;
    $display("[TB] cmd op=%0d data=%b count=%0d accepted t=%0d expect q=%b", op, d, cnt, cyc, q);
  endtask

  // Monitor: checks drive during RUN, Q the cycle after each step, and DONE timing.
  logic         q_pending = 1'b0;
  logic [W-1:0] q_expect;
  int           run_cnt = 0;

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      step_t s;
      done_t r;
      if (q_pending) begin
        check("q_after_step", 32'(bank_q), 32'(q_expect));
        q_pending = 1'b0;
      end
      if (busy) check("ready_low_when_busy", 32'(cmd_ready), 32'd0);
      if (busy && !done) begin
        run_cnt++;
        if (step_q.size() == 0) begin
          check("unexpected_step_en", 32'(en_out), 32'd0);
        end else begin
          s = step_q.pop_front();
          check("step_en", 32'(en_out), 32'(s.en));
          check("step_j", 32'(j_out), 32'(s.j));
          check("step_k", 32'(k_out), 32'(s.k));
          q_expect  = s.q;
          q_pending = 1'b1;
        end
      end else begin
        check("idle_drive_zero", {20'd0, en_out, j_out, k_out}, 32'd0);
      end
      if (done) begin
        if (done_q.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          r = done_q.pop_front();
          check("done_cycle", 32'(cyc), 32'(r.t + r.n));
          check("run_cycles", 32'(run_cnt), 32'(r.n));
          check("final_q", 32'(bank_q), 32'(r.q));
          $display("[TB] done t=%0d n=%0d q=%b", cyc, r.n, bank_q);
        end
        run_cnt = 0;
      end
    end
  end

  task automatic drain();
    int waited;
    waited = 0;
    while ((done_q.size() != 0 || step_q.size() != 0) && waited < 500) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check("drain_timeout", 32'(done_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with a command pending: nothing may be accepted.
    rst       = 1'b1;
    cmd_valid = 1'b1;
    cmd_op    = OP_LOAD;
    cmd_data  = '1;
    repeat (2) begin
      @(negedge clk);
      check("rst_ready", 32'(cmd_ready), 32'd0);
      check("rst_en", 32'(en_out), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
    end
    @(posedge clk);
    #1;
    rst       = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(cmd_ready), 32'd1);
    check("post_rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    check("post_rst_nothing_latched", 32'(bank_q), 32'd0);
    mon_en = 1'b1;

    send(OP_LOAD, 4'b1010, 8'd0);
    send(OP_LOAD, 4'b1110, 8'd0);
    send(OP_UP, 4'b0000, 8'd3);
    send(OP_DOWN, 4'b0000, 8'd0);
    send(OP_NOP, 4'b1111, 8'd5);
    send(OP_LOAD, 4'b1001, 8'd0);
    send(OP_ROTL, 4'b0000, 8'd4);
    send(OP_TOGGLE, 4'b0110, 8'd0);
    send(OP_DOWN, 4'b0000, 8'd0);
    send(OP_CLEAR, 4'b0000, 8'd0);
    send(OP_DOWN, 4'b0000, 8'd2);
    send(OP_SET, 4'b0000, 8'd0);
    send(OP_UP, 4'b0000, 8'd1);
    send(OP_ROTL, 4'b0000, 8'd9);
    for (int i = 0; i < 60; i++) begin
      logic [2:0]    op;
      logic [W-1:0]  d;
      logic [CW-1:0] c;
      op = 3'($urandom_range(0, 7));
      d  = W'($urandom);
      c  = ($urandom_range(0, 4) == 0) ? CW'($urandom_range(0, 40)) : CW'($urandom_range(0, 9));
      send(op, d, c);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
      end
    end
    drain();

    // Abort COUNT_UP x10 from 0000 with RST in the 4th RUN cycle.
    send(OP_LOAD, 4'b0000, 8'd0);
    drain();
    mon_en    = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = OP_UP;
    cmd_data  = '0;
    cmd_count = 8'd10;
    check("abort_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(negedge clk);
    check("abort_en_zero", 32'(en_out), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_q", 32'(bank_q), 32'd3);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready_after", 32'(cmd_ready), 32'd1);
    check("abort_busy_after", 32'(busy), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("abort_no_done", 32'(done), 32'd0);
      check("abort_q_hold", 32'(bank_q), 32'd3);
    end
    $display("[TB] abort test q=%b", bank_q);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
